// File: rtl/ex_mem_pkg.sv
// Shared defaults and state encoding for the EX/MEM skid-register stage.
package ex_mem_pkg;

  localparam int CTRL_W_DEF = 5;
  localparam int DATA_W_DEF = 32;
  localparam int RD_W_DEF   = 5;
  localparam int PC_W_DEF   = 15;

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

endpackage

// File: rtl/ex_mem_stage_slot.sv
// One storage slot of the stage: a load-enabled register holding the packed entry.
module stage_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline stage built as a 2-entry skid register: the main slot always
// drives the outputs, the skid slot absorbs one entry while downstream stalls.
module ex_mem_stage
  import ex_mem_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_W   = RD_W_DEF,
  parameter int PC_W   = PC_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic [DATA_W-1:0] alu_in,
  input  logic [DATA_W-1:0] wdata_in,
  input  logic [RD_W-1:0]   rd_in,
  input  logic [PC_W-1:0]   pc_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic [DATA_W-1:0] alu_out,
  output logic [DATA_W-1:0] wdata_out,
  output logic [RD_W-1:0]   rd_out,
  output logic [PC_W-1:0]   pc_out,
  output logic [1:0]        occupancy
);

  localparam int ENTRY_W = CTRL_W + 2 * DATA_W + RD_W + PC_W;
  localparam int MAIN    = 0;
  localparam int SKID    = 1;

  state_t state_reg, state_next;
  logic   acc_evt, rel_evt;
  logic   main_from_skid;

  logic [ENTRY_W-1:0] in_entry;
  logic [ENTRY_W-1:0] slot_d [2];
  logic [ENTRY_W-1:0] slot_q [2];
  logic [1:0]         slot_load;

  // Handshake status depends on registered state only, so out_ready never
  // reaches in_ready combinationally.
  assign in_ready  = (state_reg != FULL);
  assign out_valid = (state_reg != EMPTY);
  assign occupancy = state_reg;
  assign acc_evt   = in_valid && in_ready;
  assign rel_evt   = out_valid && out_ready;

  assign in_entry     = {ctrl_in, alu_in, wdata_in, rd_in, pc_in};
  assign slot_d[MAIN] = main_from_skid ? slot_q[SKID] : in_entry;
  assign slot_d[SKID] = in_entry;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    slot_load      = 2'b00;
    main_from_skid = 1'b0;
    if (flush) begin
      // Slots keep their contents so the outputs hold their last values.
      state_next = EMPTY;
    end else begin
      unique case (state_reg)
        EMPTY: begin
          if (acc_evt) begin
            slot_load[MAIN] = 1'b1;
            state_next      = ONE;
          end
        end
        ONE: begin
          if (acc_evt && rel_evt) begin
            slot_load[MAIN] = 1'b1;
          end else if (acc_evt) begin
            slot_load[SKID] = 1'b1;
            state_next      = FULL;
          end else if (rel_evt) begin
            state_next = EMPTY;
          end
        end
        FULL: begin
          if (rel_evt) begin
            slot_load[MAIN] = 1'b1;
            main_from_skid  = 1'b1;
            state_next      = ONE;
          end
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_slot
      stage_slot #(.W(ENTRY_W)) u_slot (
        .clk  (clk),
        .rst_n(rst_n),
        .load (slot_load[gi]),
        .d    (slot_d[gi]),
        .q    (slot_q[gi])
      );
    end
  endgenerate

  assign {ctrl_out, alu_out, wdata_out, rd_out, pc_out} = slot_q[MAIN];

endmodule

// File: tb/tb_ex_mem_stage.sv
// Randomized and directed checks of ex_mem_stage against a queue-based FIFO model.
module tb_ex_mem_stage;

  localparam int CW = 5;
  localparam int DW = 64;
  localparam int RW = 5;
  localparam int PW = 32;

  typedef struct packed {
    logic [CW-1:0] ctrl;
    logic [DW-1:0] alu;
    logic [DW-1:0] wdata;
    logic [RW-1:0] rd;
    logic [PW-1:0] pc;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic          in_ready;
  logic          out_valid;
  logic [1:0]    occupancy;
  logic [CW-1:0] ctrl_out;
  logic [DW-1:0] alu_out;
  logic [DW-1:0] wdata_out;
  logic [RW-1:0] rd_out;
  logic [PW-1:0] pc_out;
  ent_t          in_ent = '0;

  ent_t q[$];
  ent_t last_head = '0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ex_mem_stage #(.CTRL_W(CW), .DATA_W(DW), .RD_W(RW), .PC_W(PW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .ctrl_in  (in_ent.ctrl),
    .alu_in   (in_ent.alu),
    .wdata_in (in_ent.wdata),
    .rd_in    (in_ent.rd),
    .pc_in    (in_ent.pc),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .ctrl_out (ctrl_out),
    .alu_out  (alu_out),
    .wdata_out(wdata_out),
    .rd_out   (rd_out),
    .pc_out   (pc_out),
    .occupancy(occupancy)
  );

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic ent_t rand_ent();
    ent_t e;
    e.ctrl  = CW'($urandom);
    e.alu   = {$urandom, $urandom};
    e.wdata = {$urandom, $urandom};
    e.rd    = RW'($urandom);
    e.pc    = $urandom;
    return e;
  endfunction

  task automatic compare_all(input string tag);
    ent_t head_exp;
    head_exp = (q.size() != 0) ? q[0] : last_head;
    check({tag, "_occ"}, occupancy, q.size());
    check({tag, "_out_valid"}, out_valid, q.size() != 0);
    check({tag, "_in_ready"}, in_ready, q.size() < 2);
    check({tag, "_head"}, {ctrl_out, alu_out, wdata_out, rd_out, pc_out}, head_exp);
  endtask

  // One clock: the model applies the handshake rules at the edge, then the
  // DUT is compared on the falling edge.
  task automatic step(input string tag);
    bit acc, rel;
    @(posedge clk);
    acc = in_valid && (q.size() < 2);
    rel = (q.size() != 0) && out_ready;
    if (flush) begin
      q.delete();
    end else begin
      if (rel) void'(q.pop_front());
      if (acc) q.push_back(in_ent);
    end
    if (q.size() != 0) last_head = q[0];
    @(negedge clk);
    compare_all(tag);
  endtask

  task automatic model_reset();
    q.delete();
    last_head = '0;
  endtask

  initial begin
    ent_t e;
    model_reset();
    #2;
    check("reset_occ", occupancy, 2'd0);
    check("reset_in_ready", in_ready, 1'b1);
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_fields", {ctrl_out, alu_out, wdata_out, rd_out, pc_out}, 170'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Stream with no backpressure
    out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      e = rand_ent();
      e.pc = i;
      in_ent = e;
      in_valid = 1'b1;
      step("stream");
      check("stream_pc", pc_out, i);
      check("stream_occ", occupancy, 2'd1);
    end
    in_valid = 1'b0;
    step("stream_drain");

    // Backpressure fills both slots, then drains in order
    out_ready = 1'b0;
    e = rand_ent(); e.alu = 64'hA; in_ent = e; in_valid = 1'b1;
    step("bp");
    e = rand_ent(); e.alu = 64'hB; in_ent = e;
    step("bp");
    check("bp_occ_full", occupancy, 2'd2);
    check("bp_in_ready", in_ready, 1'b0);
    e = rand_ent(); in_ent = e;
    step("bp_stall");
    in_valid = 1'b0;
    check("bp_first", alu_out, 64'hA);
    out_ready = 1'b1;
    step("bp_drain");
    check("bp_second", alu_out, 64'hB);
    step("bp_drain");
    check("bp_empty", out_valid, 1'b0);

    // Flush while full discards the concurrent accept
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_ent = rand_ent(); step("fl_fill");
    in_ent = rand_ent(); step("fl_fill");
    e = rand_ent(); e.rd = 5'd7; in_ent = e;
    flush = 1'b1;
    step("flush");
    check("flush_out_valid", out_valid, 1'b0);
    check("flush_occ", occupancy, 2'd0);
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step("post_flush");
      check("post_flush_valid", out_valid, 1'b0);
    end

    // Asynchronous reset between edges while full
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_ent = rand_ent(); step("rst_fill");
    in_ent = rand_ent(); step("rst_fill");
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    compare_all("midreset");
    check("midreset_in_ready", in_ready, 1'b1);
    #1;
    rst_n = 1'b1;
    step("after_reset");

    // Full-width value passes unmodified
    out_ready = 1'b1;
    e = rand_ent(); e.alu = 64'hFFFF_FFFF_FFFF_FFFF; e.pc = 32'hFFFF_FFFF;
    in_ent = e; in_valid = 1'b1;
    step("wide");
    check("wide_alu", alu_out, 64'hFFFF_FFFF_FFFF_FFFF);
    check("wide_pc", pc_out, 32'hFFFF_FFFF);
    in_valid = 1'b0;
    step("wide_drain");

    // Random traffic, occasional flush
    for (int i = 0; i < 10000; i++) begin
      in_valid  = $urandom_range(1, 0) == 1;
      out_ready = $urandom_range(1, 0) == 1;
      flush     = $urandom_range(63, 0) == 0;
      in_ent    = rand_ent();
      step("rand");
    end
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    step("final_drain");
    step("final_drain");
    check("final_empty", out_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage.md
EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-002 Parameter CTRL_W, default 5, SHALL set the control field width.
REQ-003 Parameter DATA_W, default 32, SHALL set the ALU result and store-data widths.
REQ-004 Parameter RD_W, default 5, SHALL set the destination register index width.
REQ-005 Parameter PC_W, default 15, SHALL set the PC width.
REQ-006 The ports SHALL be, in order:
- clk  in  1  rising-edge clock
- rst_n  in  1  async active-low reset
- flush  in  1  discard all held entries
- in_valid  in  1  upstream has an entry
- in_ready  out  1  stage can accept
- ctrl_in  in  CTRL_W  control field
- alu_in  in  DATA_W  ALU result
- wdata_in  in  DATA_W  store data
- rd_in  in  RD_W  destination register
- pc_in  in  PC_W  PC
- out_valid  out  1  stage holds an entry
- out_ready  in  1  downstream accepts
- ctrl_out, alu_out, wdata_out, rd_out, pc_out  out  (matching widths)  head entry fields
- occupancy  out  2  entries held (0..2)

Function
REQ-007 The stage SHALL be a 2-entry skid register: main slot (head) and skid slot.
REQ-008 An accept SHALL occur when in_valid and in_ready are both 1 at a rising edge.
REQ-009 A release SHALL occur when out_valid and out_ready are both 1 at a rising edge.
REQ-010 States SHALL be EMPTY (0), ONE (1) and FULL (2); occupancy SHALL equal the state value.
REQ-011 in_ready SHALL be 1 exactly when the state is not FULL, decoded from registered state only, with no combinational path from out_ready.
REQ-012 out_valid SHALL be 1 exactly when the state is not EMPTY; output fields SHALL always drive the main slot.
REQ-013 From EMPTY, an accept SHALL load main and go to ONE.
REQ-014 From ONE, accept with release SHALL load main and stay ONE; accept alone SHALL load skid and go to FULL; release alone SHALL go to EMPTY.
REQ-015 From FULL, a release SHALL copy skid to main and go to ONE; no accept is possible.
REQ-016 Latency SHALL be 1 cycle: an entry accepted at edge N SHALL be visible on the outputs after edge N if it enters main.
REQ-017 Ordering SHALL be strict FIFO; no entry SHALL be duplicated or dropped except by flush.
REQ-018 flush SHALL take priority over all other events: next state EMPTY, and any concurrent accept discarded.
REQ-019 Slots not loaded in a cycle SHALL hold their value; a data-field change on the outputs while out_valid=1 and out_ready=0 SHALL be a violation.
REQ-020 After a release to EMPTY or a flush, output fields SHALL hold their last values while out_valid=0.

Reset
REQ-021 While rst_n=0, the state SHALL be EMPTY and all slot fields 0; thus out_valid=0, occupancy=0, in_ready=1 and all output fields 0.
REQ-022 Reset SHALL act immediately and mid-transfer, discarding held entries.
REQ-023 The first accept SHALL be possible at the first rising edge after rst_n deasserts.

Structure
REQ-024 Package ex_mem_pkg SHALL hold default widths and the EMPTY/ONE/FULL state encoding.
REQ-025 One sub-module, stage_slot, SHALL be used twice: a load-enabled register of the concatenated fields with async reset to 0.
REQ-026 The FSM and slot-mux logic SHALL reside in ex_mem_stage.

Verification
REQ-027 Stream: out_ready=1; accept pc 1, 2, 3 on consecutive cycles -> out pc 1, 2, 3 one cycle later each; occupancy stays 1.
REQ-028 Backpressure: out_ready=0; accept alu 0xA, then 0xB -> occupancy 2 and in_ready=0; then out_ready=1 -> 0xA, then 0xB, with no loss.
REQ-029 Flush: FULL state; flush=1 with in_valid=1 (rd 7) -> next cycle out_valid=0 and occupancy 0; rd 7 is never output.
REQ-030 Reset mid-op: FULL state; rst_n pulsed low between edges -> outputs 0 and in_ready=1 immediately.
REQ-031 Random: in_valid and out_ready each at 50% for 10k cycles -> output sequence equals the accepted sequence; no change while stalled.
REQ-032 Widths: DATA_W=64, PC_W=32, with alu 0xFFFF_FFFF_FFFF_FFFF -> passed unmodified.
